// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer / deserializer pair.
package serdes_pkg;

   // Default parallel word width used by both directions.
   localparam int unsigned DEFAULT_DATA_W = 8;

   // Shifter state encoding, common to serializer and deserializer.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shift_state_e;

endpackage

// File: rtl/parallel2serial.sv
// Parallel-to-serial converter with a one-entry holding register in front of
// the shifter, so a new word can be accepted while the previous one shifts out.
module parallel2serial
   import serdes_pkg::*;
#(
   parameter int unsigned DATA_W    = DEFAULT_DATA_W,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_parallel,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dout_serial,
   output logic              dout_valid,
   output logic              dout_last
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] hold_q;
   logic              hold_full_q;
   logic [DATA_W-1:0] shreg_q;
   logic [CNT_W-1:0]  cnt_q;
   shift_state_e      state_q;

   logic accept;
   logic load;

   // Bit that goes out first from a word, honouring the bit order.
   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // Word with its outgoing bit removed, remaining bits moved toward the exit.
   function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   // Ready comes straight from the holding flag flop; no path from din_valid.
   assign din_ready = ~hold_full_q;
   assign accept    = din_valid & ~hold_full_q;
   // Load when idle, or on the last bit of a word so words stream without gaps.
   assign load      = hold_full_q & ((state_q == IDLE) | (cnt_q == CNT_MAX));

   // Holding register: captures an accepted word, releases it to the shifter.
   // accept needs hold_full_q=0 and load needs hold_full_q=1, so they never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else if (accept) begin
         hold_q      <= din_parallel;
         hold_full_q <= 1'b1;
      end else if (load) begin
         hold_full_q <= 1'b0;
      end
   end

   // Shifter FSM with registered serial outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         dout_serial <= 1'b0;
         dout_valid  <= 1'b0;
         dout_last   <= 1'b0;
      end else if (load) begin
         state_q     <= SHIFT;
         cnt_q       <= '0;
         shreg_q     <= drop_bit(hold_q);
         dout_serial <= first_bit(hold_q);
         dout_valid  <= 1'b1;
         dout_last   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q       <= '0;
               dout_serial <= 1'b0;
               dout_valid  <= 1'b0;
               dout_last   <= 1'b0;
            end
            SHIFT: begin
               if (cnt_q == CNT_MAX) begin
                  // Word finished and nothing held: go quiet.
                  state_q     <= IDLE;
                  cnt_q       <= '0;
                  dout_serial <= 1'b0;
                  dout_valid  <= 1'b0;
                  dout_last   <= 1'b0;
               end else begin
                  cnt_q       <= cnt_q + CNT_W'(1);
                  shreg_q     <= drop_bit(shreg_q);
                  dout_serial <= first_bit(shreg_q);
                  dout_valid  <= 1'b1;
                  dout_last   <= ((cnt_q + CNT_W'(1)) == CNT_MAX);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
